seven_segment_reader: RTL and testbench

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_reader.sv | 169 ++++++++++++++++
 tb/tb_seven_segment_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// -----------------------------------------------------------------------------
// seven_segment_reader
//
// Reads a two-digit multiplexed seven-segment display by sniffing its segment
// and digit-strobe lines. Each strobe/segment combination must stay unchanged
// for STABLE_CYCLES samples before it counts as a digit. After both the tens
// and the ones digit have been captured, the frame is published as BCD digits
// and as a binary value, and valid pulses for one cycle. A pattern that is not
// a decimal digit pulses err and drops the digit captured in that slot.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept a digit (2..15)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   seg      in   [6:0] segment lines a..g on bits 0..6, active high
//   dig_sel  in   [1:0] one-hot digit strobe, bit0 = ones, bit1 = tens
//   value    out  [6:0] tens*10 + ones of the last complete frame
//   tens     out  [3:0] BCD tens digit of the last complete frame
//   ones     out  [3:0] BCD ones digit of the last complete frame
//   valid    out  one-cycle pulse when a new frame is published
//   err      out  one-cycle pulse when an illegal pattern is accepted
// -----------------------------------------------------------------------------
module seven_segment_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [1:0] dig_sel,
    output logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid,
    output logic       err
);

    typedef enum logic {
        SCAN = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam int              CW        = 4;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(STABLE_CYCLES - 1);

    // Maps a segment pattern to {legal, digit}; anything not in the table is illegal.
    function automatic logic [4:0] decode(input logic [6:0] pattern);
        logic [4:0] result;
        case (pattern)
            7'h3F:   result = {1'b1, 4'd0};
            7'h06:   result = {1'b1, 4'd1};
            7'h5B:   result = {1'b1, 4'd2};
            7'h4F:   result = {1'b1, 4'd3};
            7'h66:   result = {1'b1, 4'd4};
            7'h6D:   result = {1'b1, 4'd5};
            7'h7D:   result = {1'b1, 4'd6};
            7'h07:   result = {1'b1, 4'd7};
            7'h7F:   result = {1'b1, 4'd8};
            7'h6F:   result = {1'b1, 4'd9};
            default: result = 5'b0;
        endcase
        return result;
    endfunction

    logic [6:0]    seg_q;
    logic [1:0]    sel_q;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          have_ones;
    logic          have_tens;
    logic [3:0]    ones_d;
    logic [3:0]    tens_d;

    logic          changed;
    logic          sel_one_hot;
    logic          capture;
    logic          legal;
    logic [3:0]    digit;
    logic          bad_capture;
    logic          complete;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave a value undefined and infer a latch.
    always_comb begin
        changed     = 1'b0;
        sel_one_hot = 1'b0;
        capture     = 1'b0;
        legal       = 1'b0;
        digit       = 4'd0;
        bad_capture = 1'b0;
        complete    = 1'b0;

        // The sample about to enter seg_q/sel_q differs from the one held now.
        changed     = {seg, dig_sel} != {seg_q, sel_q};
        sel_one_hot = (sel_q == 2'b01) || (sel_q == 2'b10);
        {legal, digit} = decode(seg_q);

        // The counter reaches STABLE_CYCLES on this edge only when it is one
        // short and the sample repeats; a held pattern sits in HELD afterwards,
        // so it is captured exactly once.
        capture     = (state == SCAN) && !changed && (cnt == CNT_LAST) && sel_one_hot;
        bad_capture = capture && !legal;

        // An illegal capture on the completing edge wins: no frame is published.
        complete    = have_ones && have_tens && !bad_capture;
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others, independent of
    // statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q     <= '0;
            sel_q     <= '0;
            cnt       <= '0;
            state     <= SCAN;
            have_ones <= 1'b0;
            have_tens <= 1'b0;
            ones_d    <= '0;
            tens_d    <= '0;
            value     <= '0;
            tens      <= '0;
            ones      <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            seg_q <= seg;
            sel_q <= dig_sel;

            if (changed) begin
                cnt <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end

            case (state)
                SCAN: if (capture) state <= HELD;
                HELD: if (changed) state <= SCAN;
                default: state <= SCAN;
            endcase

            valid <= complete;
            err   <= bad_capture;

            if (complete) begin
                tens      <= tens_d;
                ones      <= ones_d;
                value     <= ({3'b000, tens_d} * 7'd10) + {3'b000, ones_d};
                have_ones <= 1'b0;
                have_tens <= 1'b0;
            end

            // Placed after the completion clear so a capture on the same edge
            // would still be recorded for the following frame.
            if (capture) begin
                if (sel_q[0]) begin
                    have_ones <= legal;
                    if (legal) ones_d <= digit;
                end else begin
                    have_tens <= legal;
                    if (legal) tens_d <= digit;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_reader
//
// Drives seven_segment_reader with directed scenarios and random runs of
// segment/strobe patterns. A reference model predicts the outputs from the
// run length of each input pattern and the frame rules; every cycle the DUT
// outputs are compared against it, plus a few scenario-level checks.
// -----------------------------------------------------------------------------
module tb_seven_segment_reader;

    localparam int STABLE = 4;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic [6:0] value;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       valid;
    logic       err;

    seven_segment_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .dig_sel (dig_sel),
        .value   (value),
        .tens    (tens),
        .ones    (ones),
        .valid   (valid),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  codes [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    int  run_len;
    int  last_in;
    bit  m_have [2];
    int  m_dig  [2];
    int  m_value, m_tens, m_ones;
    bit  m_valid, m_err;

    function automatic int digit_of(input int pattern);
        for (int i = 0; i < 10; i++)
            if (codes[i] == pattern) return i;
        return -1;
    endfunction

    task automatic model_reset();
        run_len = 0;
        last_in = 0;
        m_have  = '{0, 0};
        m_dig   = '{0, 0};
        m_value = 0; m_tens = 0; m_ones = 0;
        m_valid = 0; m_err  = 0;
    endtask

    // One clock edge with pattern s and strobe d present at the inputs.
    task automatic model_edge(input int s, input int d);
        int  in_word;
        int  dg;
        int  slot;
        bit  cap, illegal, done;
        in_word = s * 4 + d;
        run_len = (in_word == last_in) ? run_len + 1 : 1;
        last_in = in_word;
        // A digit is taken once per run, on the sample that completes STABLE.
        cap     = (run_len == STABLE) && (d == 1 || d == 2);
        dg      = digit_of(s);
        illegal = cap && (dg < 0);
        slot    = (d == 1) ? 0 : 1;
        done    = m_have[0] && m_have[1] && !illegal;
        m_valid = done;
        m_err   = illegal;
        if (done) begin
            m_tens  = m_dig[1];
            m_ones  = m_dig[0];
            m_value = 10 * m_tens + m_ones;
            m_have  = '{0, 0};
        end
        if (cap) begin
            if (illegal) m_have[slot] = 0;
            else begin
                m_dig[slot]  = dg;
                m_have[slot] = 1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int vcount;   // valid pulses seen since last cleared
    int ecount;   // err pulses seen since last cleared

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, int'(valid), int'(m_valid));
        check({tag, ".err"},   int'(err),   int'(m_err));
        check({tag, ".value"}, int'(value), m_value);
        check({tag, ".tens"},  int'(tens),  m_tens);
        check({tag, ".ones"},  int'(ones),  m_ones);
        check({tag, ".excl"},  int'(valid && err), 0);
    endtask

    // Present pattern s with strobe d for n edges, checking after each edge.
    task automatic run(input string tag, input int s, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            seg     = 7'(s);
            dig_sel = 2'(d);
            @(posedge clk);
            model_edge(s, d);
            @(negedge clk);
            if (valid) vcount++;
            if (err)   ecount++;
            compare_all(tag);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".value"}, int'(value), 0);
        check({tag, ".tens"},  int'(tens),  0);
        check({tag, ".ones"},  int'(ones),  0);
        check({tag, ".valid"}, int'(valid), 0);
        check({tag, ".err"},   int'(err),   0);
    endtask

    // Asserts reset between edges and checks outputs clear without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, ".held"});
        model_reset();
        rst = 1'b0;
    endtask

    int rise_edge;

    initial begin
        rst     = 1'b1;
        seg     = '0;
        dig_sel = '0;
        model_reset();
        vcount = 0;
        ecount = 0;

        do_reset("init");

        // Tens 1 then ones 5 -> single frame 15.
        vcount = 0;
        run("f15_t", 'h06, 2, 6);
        run("f15_o", 'h6D, 1, 6);
        check("f15.pulses", vcount, 1);
        check("f15.value", int'(value), 15);
        check("f15.tens",  int'(tens),  1);
        check("f15.ones",  int'(ones),  5);

        // Latency: valid rises on the 5th edge after the ones inputs appear.
        run("lat_t", 'h5B, 2, 6);
        rise_edge = 0;
        for (int k = 1; k <= 8; k++) begin
            run("lat_o", 'h3F, 1, 1);
            if (valid && rise_edge == 0) rise_edge = k;
        end
        check("lat.edge",  rise_edge, STABLE + 1);
        check("lat.value", int'(value), 20);

        // Short glitch of 8 is ignored; 7 is taken once tens arrives.
        ecount = 0;
        run("gl_8", 'h7F, 1, 3);
        run("gl_7", 'h07, 1, 6);
        run("gl_t", 'h4F, 2, 6);
        check("gl.ones", int'(ones), 7);
        check("gl.tens", int'(tens), 3);
        check("gl.err",  ecount, 0);

        // Illegal pattern on tens: one err, no frame, value kept.
        vcount = 0; ecount = 0;
        run("ill", 'h49, 2, 6);
        run("ill_o", 'h3F, 1, 6);
        check("ill.err",   ecount, 1);
        check("ill.valid", vcount, 0);
        check("ill.value", int'(value), 37);

        // Tens captured, reset, then ones only: no frame until new tens.
        run("rs_t", 'h7D, 2, 6);
        do_reset("rs");
        vcount = 0;
        run("rs_o", 'h3F, 1, 8);
        check("rs.valid", vcount, 0);
        run("rs_t2", 'h66, 2, 6);
        check("rs.after", vcount, 1);
        check("rs.value", int'(value), 40);

        // Both strobes active: never captured. Long hold: at most one capture.
        vcount = 0; ecount = 0;
        run("both", 'h3F, 3, 20);
        run("long", 'h6F, 2, 50);
        check("both.valid", vcount, 0);
        run("long_o", 'h06, 1, 50);
        check("long.pulses", vcount, 1);
        check("long.value",  int'(value), 91);

        // Random runs, mostly legal patterns, with occasional resets.
        for (int r = 0; r < 400; r++) begin
            int s, d, n;
            if ($urandom_range(0, 3) != 0) s = codes[$urandom_range(0, 9)];
            else                           s = int'($urandom_range(0, 127));
            d = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(1, 2));
            n = int'($urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
            run("rnd", s, d, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
